// File: rtl/rv32_mem_arbiter.sv
// Two-port arbiter sharing one single-ported BRAM between instruction fetch
// and the data port. Reads take one cycle in RD_WAIT to return BRAM data;
// writes complete in the grant cycle. Contention is resolved round-robin.
module rv32_mem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    // data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    // BRAM ports
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t state, state_nx;
    logic   last_d, last_d_nx;   // 1: data port won the most recent grant
    logic   rd_d, rd_d_nx;       // 1: outstanding read belongs to data port
    logic   pick_if, pick_d;

    // State, round-robin history and read owner registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            last_d <= 1'b1;   // fetch wins the first contention
            rd_d   <= 1'b0;
        end else begin
            state  <= state_nx;
            last_d <= last_d_nx;
            rd_d   <= rd_d_nx;
        end
    end

    // Arbitration, BRAM port drive and response routing; all outputs are
    // held at zero while rst is high so a reset during RD_WAIT drops the
    // pending response.
    always_comb begin
        state_nx  = state;
        last_d_nx = last_d;
        rd_d_nx   = rd_d;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        if_rdata  = '0;
        d_rdata   = '0;
        mem_wen   = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        mem_ren   = 1'b0;
        mem_raddr = '0;
        pick_if   = if_req && (!d_req || last_d);
        pick_d    = d_req && (!if_req || !last_d);
        case (state)
            IDLE: begin
                if (!rst) begin
                    if (pick_if) begin
                        if_gnt    = 1'b1;
                        mem_ren   = 1'b1;
                        mem_raddr = if_addr;
                        last_d_nx = 1'b0;
                        rd_d_nx   = 1'b0;
                        state_nx  = RD_WAIT;
                    end else if (pick_d) begin
                        d_gnt     = 1'b1;
                        last_d_nx = 1'b1;
                        if (d_we) begin
                            mem_wen   = 1'b1;
                            mem_waddr = d_addr;
                            mem_wdata = d_wdata;
                        end else begin
                            mem_ren   = 1'b1;
                            mem_raddr = d_addr;
                            rd_d_nx   = 1'b1;
                            state_nx  = RD_WAIT;
                        end
                    end
                end
            end
            RD_WAIT: begin
                state_nx = IDLE;
                if (!rst) begin
                    if (rd_d) begin
                        d_rvalid = 1'b1;
                        d_rdata  = mem_rdata;
                    end else begin
                        if_rvalid = 1'b1;
                        if_rdata  = mem_rdata;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Bench for rv32_mem_arbiter: directed scenarios followed by randomized
// requesters, all compared against a transaction-level reference model
// (memory image, one pending response slot, last-winner flag).
module tb_rv32_mem_arbiter;
    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          if_gnt, if_rvalid, d_gnt, d_rvalid;
    logic [DW-1:0] if_rdata, d_rdata;
    logic          mem_wen, mem_ren;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          clr;

    rv32_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // BRAM with one-cycle registered read
    logic [DW-1:0] bram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < (1<<AW); i++) bram[i] <= '0;
        end else if (mem_wen) begin
            bram[mem_waddr] <= mem_wdata;
        end
        if (mem_ren) mem_rdata <= bram[mem_raddr];
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // reference model
    logic [DW-1:0] m_mem [0:(1<<AW)-1];
    bit            m_last_d;
    bit            m_pend, m_pend_d;
    logic [DW-1:0] m_pend_data;
    bit            e_ifg, e_dg;
    bit            o_ifg, o_dg, o_ifv, o_dv, o_wen;
    logic [DW-1:0] o_if_rdata, o_d_rdata;

    // One clock: check DUT outputs at the falling edge against the model,
    // advance the model, then return 1ns after the rising edge.
    task automatic cycle();
        bit ifg, dg, ifv, dv, wd;
        logic [DW-1:0] rd;
        @(negedge clk);
        ifg = 0; dg = 0; ifv = 0; dv = 0; rd = '0; wd = 0;
        if (!rst) begin
            if (m_pend) begin
                if (m_pend_d) dv = 1; else ifv = 1;
                rd = m_pend_data;
            end else if (if_req || d_req) begin
                wd  = d_req && (!if_req || !m_last_d);
                dg  = wd;
                ifg = !wd;
            end
        end
        chk("if_gnt",    32'(if_gnt),    32'(ifg));
        chk("d_gnt",     32'(d_gnt),     32'(dg));
        chk("if_rvalid", 32'(if_rvalid), 32'(ifv));
        chk("d_rvalid",  32'(d_rvalid),  32'(dv));
        chk("if_rdata",  if_rdata, ifv ? rd : 32'h0);
        chk("d_rdata",   d_rdata,  dv ? rd : 32'h0);
        chk("mem_ren",   32'(mem_ren), 32'(ifg || (dg && !d_we)));
        chk("mem_wen",   32'(mem_wen), 32'(dg && d_we));
        if (ifg)          chk("mem_raddr_if", 32'(mem_raddr), 32'(if_addr));
        if (dg && !d_we)  chk("mem_raddr_d",  32'(mem_raddr), 32'(d_addr));
        if (dg && d_we) begin
            chk("mem_waddr", 32'(mem_waddr), 32'(d_addr));
            chk("mem_wdata", mem_wdata, d_wdata);
        end
        o_ifg = if_gnt; o_dg = d_gnt; o_ifv = if_rvalid; o_dv = d_rvalid;
        o_wen = mem_wen; o_if_rdata = if_rdata; o_d_rdata = d_rdata;
        if (rst) begin
            m_last_d = 1; m_pend = 0;
        end else if (m_pend) begin
            m_pend = 0;
        end else if (ifg) begin
            m_last_d = 0; m_pend = 1; m_pend_d = 0; m_pend_data = m_mem[if_addr];
        end else if (dg) begin
            m_last_d = 1;
            if (d_we) m_mem[d_addr] = d_wdata;
            else begin
                m_pend = 1; m_pend_d = 1; m_pend_data = m_mem[d_addr];
            end
        end
        e_ifg = ifg; e_dg = dg;
        @(posedge clk); #1;
    endtask

    task automatic drv(input bit ir, input logic [AW-1:0] ia, input bit dr, input bit we,
                       input logic [AW-1:0] da, input logic [DW-1:0] wd);
        if_req = ir; if_addr = ia; d_req = dr; d_we = we; d_addr = da; d_wdata = wd;
    endtask

    bit seq [0:7];
    int ng;

    initial begin
        for (int i = 0; i < (1<<AW); i++) m_mem[i] = '0;
        m_last_d = 1; m_pend = 0; m_pend_d = 0; m_pend_data = '0;

        // reset with both requesting: everything must stay quiet
        rst = 1; clr = 1;
        drv(1, 10'd1, 1, 0, 10'd2, 32'h0);
        cycle();
        clr = 0;
        cycle();
        chk("rst_quiet", 32'(o_ifg | o_dg | o_ifv | o_dv | o_wen), 32'h0);
        rst = 0;

        // contention right after reset: fetch first, data two cycles later
        drv(1, 10'd4, 1, 0, 10'd7, 32'h0);
        cycle(); chk("cont_if_first", 32'(o_ifg), 32'h1);
        if_req = 0;
        cycle(); chk("cont_if_rvalid", 32'(o_ifv), 32'h1);
        cycle(); chk("cont_d_gnt_T2", 32'(o_dg), 32'h1);
        d_req = 0;
        cycle(); chk("cont_d_rvalid_T3", 32'(o_dv), 32'h1);

        // fetch-only read of a preloaded word
        drv(0, 10'd0, 1, 1, 10'd5, 32'hDEADBEEF);
        cycle();
        drv(1, 10'd5, 0, 0, 10'd0, 32'h0);
        cycle(); chk("fetch_gnt", 32'(o_ifg), 32'h1);
        if_req = 0;
        cycle(); chk("fetch_rdata", o_if_rdata, 32'hDEADBEEF);

        // write then read-back on the next cycle
        drv(0, 10'd0, 1, 1, 10'd3, 32'h12345678);
        cycle(); chk("wr_wen", 32'(o_wen), 32'h1);
        drv(0, 10'd0, 1, 0, 10'd3, 32'h0);
        cycle(); chk("rd_gnt", 32'(o_dg), 32'h1);
        d_req = 0;
        cycle(); chk("wr_rd_data", o_d_rdata, 32'h12345678);

        // back-to-back writes
        for (int i = 0; i < 4; i++) begin
            drv(0, 10'd0, 1, 1, AW'(i), 32'(100 + i));
            cycle();
            chk("b2b_gnt", 32'(o_dg), 32'h1);
            chk("b2b_wen", 32'(o_wen), 32'h1);
        end
        d_req = 0;

        // round-robin with both ports requesting continuously
        ng = 0;
        drv(1, 10'd1, 1, 0, 10'd2, 32'h0);
        for (int c = 0; c < 40 && ng < 8; c++) begin
            cycle();
            if (o_ifg || o_dg) begin
                seq[ng] = o_dg;
                ng++;
                if (o_ifg) if_addr = if_addr + 1'b1;
                else       d_addr  = d_addr + 1'b1;
            end
        end
        chk("rr_grant_count", 32'(ng), 32'd8);
        for (int i = 0; i < 8; i++) chk("rr_alternate", 32'(seq[i]), 32'(i % 2));
        drv(0, 10'd0, 0, 0, 10'd0, 32'h0);
        cycle();

        // reset in the middle of a fetch read
        drv(1, 10'd9, 0, 0, 10'd0, 32'h0);
        cycle(); chk("midrst_gnt", 32'(o_ifg), 32'h1);
        if_req = 0; rst = 1;
        cycle(); chk("midrst_no_rvalid", 32'(o_ifv), 32'h0);
        rst = 0;
        cycle(); chk("midrst_no_late_rvalid", 32'(o_ifv), 32'h0);
        drv(1, 10'd6, 1, 0, 10'd8, 32'h0);
        cycle(); chk("midrst_if_first", 32'(o_ifg), 32'h1);
        drv(0, 10'd0, 0, 0, 10'd0, 32'h0);
        cycle();

        // randomized requesters that hold their request until granted
        for (int c = 0; c < 3000; c++) begin
            cycle();
            rst = ($urandom_range(0, 99) == 0);
            if (e_ifg || !if_req) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = AW'($urandom_range(0, 15));
            end
            if (e_dg || !d_req) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = $urandom_range(0, 1) != 0;
                d_addr  = AW'($urandom_range(0, 15));
                d_wdata = $urandom;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/rv32_mem_arbiter.md
RV32_MEM_ARBITER -- requirements
Module: rv32_mem_arbiter

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, the word width of the shared BRAM.
REQ-002 The module SHALL have parameter ADDR_W, default 10, the word-address width of the shared BRAM.
REQ-003 clk  input  1  single clock for all logic, rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 if_req  input  1  instruction-fetch read request, held until granted.
REQ-006 if_addr  input  ADDR_W  fetch word address.
REQ-007 if_gnt  output  1  fetch request accepted this cycle.
REQ-008 if_rvalid  output  1  fetch read data valid.
REQ-009 if_rdata  output  DATA_W  fetch read data.
REQ-010 d_req  input  1  data-port request, held until granted.
REQ-011 d_we  input  1  data request is a write (1) or read (0).
REQ-012 d_addr  input  ADDR_W  data word address.
REQ-013 d_wdata  input  DATA_W  store data.
REQ-014 d_gnt  output  1  data request accepted this cycle; for writes this is the completion.
REQ-015 d_rvalid  output  1  data read data valid.
REQ-016 d_rdata  output  DATA_W  data read data.
REQ-017 mem_wen, mem_waddr[ADDR_W], mem_wdata[DATA_W]  outputs  BRAM write port.
REQ-018 mem_ren, mem_raddr[ADDR_W]  outputs; mem_rdata[DATA_W]  input  BRAM read port, one-cycle registered read latency.

Function
REQ-019 The FSM SHALL have two states: IDLE and RD_WAIT.
REQ-020 In IDLE, if exactly one of if_req and d_req is high, that requester SHALL be granted in the same cycle (combinational gnt).
REQ-021 In IDLE, if both are high, the requester not recorded in the last_gnt register SHALL win; last_gnt SHALL update to the winner on every grant.
REQ-022 The if_gnt and d_gnt outputs SHALL never both be high; neither SHALL be high in RD_WAIT.
REQ-023 A granted read (fetch, or data with d_we=0) SHALL drive mem_ren=1 and mem_raddr=the winner's address in the grant cycle, then move to RD_WAIT.
REQ-024 In RD_WAIT, the granted port's rvalid SHALL be 1 and its rdata SHALL equal mem_rdata; the FSM SHALL return to IDLE unconditionally.
REQ-025 Read latency SHALL be gnt at cycle T and rvalid at T+1; read throughput SHALL be at most one read per 2 cycles.
REQ-026 A granted write SHALL drive mem_wen=1, mem_waddr=d_addr and mem_wdata=d_wdata in the grant cycle, and the FSM SHALL stay in IDLE, so back-to-back writes are possible every cycle.
REQ-027 When rvalid is 0, rdata for that port SHALL be all zeros; mem_wen and mem_ren SHALL be 0 when no matching grant occurs.
REQ-028 A write granted in cycle T SHALL be visible to a read granted in cycle T+1 or later.
REQ-029 Requests arriving during RD_WAIT SHALL be arbitrated in the following IDLE cycle; requesters hold req, addr, we and wdata stable until gnt.
REQ-030 The arbiter SHALL ignore the req-drop behaviour of a requester before gnt and SHALL be required to be free of lockup.

Reset
REQ-031 While rst=1 at a clock edge, the state SHALL go to IDLE and last_gnt SHALL be set to DATA, so fetch wins the first contention.
REQ-032 During and immediately after reset, all gnt, rvalid, mem_wen and mem_ren outputs SHALL be 0, and all rdata outputs SHALL be zeros.
REQ-033 A reset asserted while in RD_WAIT SHALL suppress the pending rvalid; no response SHALL appear after reset deasserts.

Verification
REQ-034 Fetch-only read: preload mem[5]=0xDEADBEEF, if_req=1, if_addr=5 -> if_gnt at T, mem_ren=1, mem_raddr=5; if_rvalid=1 with if_rdata=0xDEADBEEF at T+1.
REQ-035 Contention after reset: if_req=d_req=1 (d read addr 7) -> fetch granted first; data granted at T+2; d_rvalid at T+3.
REQ-036 Round-robin fairness: both ports request continuously for 8 grants -> grants strictly alternate IF, D, IF, D, and no port waits more than 2 grant slots.
REQ-037 Write then read: d write addr 3 data 0x12345678 at T (d_gnt, mem_wen=1), d read addr 3 at T+1 -> d_rdata=0x12345678 at T+2.
REQ-038 Back-to-back writes: d_req=1, d_we=1 for 4 consecutive cycles to addresses 0..3 -> d_gnt=1 in all 4 cycles, with mem_wen=1 each cycle.
REQ-039 Reset mid-read: grant a fetch at T, rst=1 at T+1 -> if_rvalid=0 at T+1 onward; state IDLE; next contention grants fetch first.
